// File: rtl/sar_search_8b.sv
// Successive-approximation controller: drives Q into an external magnitude
// comparator and rebuilds the hidden operand P from the GT/EQ/LT flags.
module sar_search_8b #(
  parameter int BITS   = 8,
  parameter int SETTLE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            PGTQ,
  input  logic            PEQQ,
  input  logic            PLTQ,
  output logic [BITS-1:0] Q,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] result,
  output logic            found,
  output logic            err,
  output logic [3:0]      trials
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EVAL, S_DONE} state_t;

  localparam logic [BITS-1:0] Q_INIT      = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] ONE         = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [3:0]      K_TOP       = 4'(BITS-1);
  localparam logic [2:0]      SETTLE_LAST = (SETTLE > 0) ? 3'(SETTLE-1) : 3'd0;
  // With no settle time a Q update goes straight to the next evaluation.
  localparam state_t          S_TRIAL     = (SETTLE > 0) ? S_WAIT : S_EVAL;

  state_t          state_q, state_d;
  logic [BITS-1:0] q_q, q_d;
  logic [3:0]      k_q, k_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [BITS-1:0] result_q, result_d;
  logic            found_q, found_d;
  logic            err_q, err_d;
  logic [3:0]      trials_q, trials_d;

  logic [BITS-1:0] bit_k;
  logic [BITS-1:0] bit_next;
  logic [2:0]      flags;
  logic            flags_one_hot;

  assign bit_k         = ONE << k_q;
  assign bit_next      = bit_k >> 1;
  assign flags         = {PGTQ, PEQQ, PLTQ};
  assign flags_one_hot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    trials_d = trials_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_d      = Q_INIT;
          k_d      = K_TOP;
          cnt_d    = 3'd0;
          trials_d = 4'd0;
          err_d    = 1'b0;
          found_d  = 1'b0;
          result_d = '0;
          state_d  = S_TRIAL;
        end
      end

      S_WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      S_EVAL: begin
        trials_d = trials_q + 4'd1;
        cnt_d    = 3'd0;
        if (!flags_one_hot) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = S_DONE;
        end else if (PEQQ) begin
          result_d = q_q;
          found_d  = 1'b1;
          state_d  = S_DONE;
        end else if (k_q != 4'd0) begin
          // GT keeps the trial bit, LT drops it; either way try the next bit down.
          q_d     = PGTQ ? (q_q | bit_next) : ((q_q & ~bit_k) | bit_next);
          k_d     = k_q - 4'd1;
          state_d = S_TRIAL;
        end else if (PLTQ) begin
          result_d = q_q & ~ONE;
          found_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          // P > Q with every bit already set cannot come from a sane comparator.
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      q_q      <= '0;
      k_q      <= 4'd0;
      cnt_q    <= 3'd0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      trials_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
      trials_q <= trials_d;
    end
  end

  assign Q      = q_q;
  assign busy   = (state_q == S_WAIT) || (state_q == S_EVAL);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign found  = found_q;
  assign err    = err_q;
  assign trials = trials_q;

endmodule

// File: tb/tb_sar_search_8b.sv
// Directed bench: one controller against an ideal comparator, one with
// SETTLE=2 against a comparator whose flags lag Q by two cycles.
module tb_sar_search_8b;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start2;

  logic [7:0] p_val;
  logic       ovr_en;
  logic [2:0] ovr_flags_v;

  logic       gt0, eq0, lt0;
  logic [7:0] q0, result0;
  logic       busy0, done0, found0, err0;
  logic [3:0] trials0;

  logic       gt2, eq2, lt2;
  logic [7:0] q2, result2;
  logic       busy2, done2, found2, err2;
  logic [3:0] trials2;
  logic [7:0] q2_d1 = 8'h00;
  logic [7:0] q2_d2 = 8'h00;
  localparam logic [7:0] P2 = 8'hFF;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign {gt0, eq0, lt0} = ovr_en ? ovr_flags_v : {p_val > q0, p_val == q0, p_val < q0};

  always @(posedge clk) begin
    q2_d1 <= q2;
    q2_d2 <= q2_d1;
  end
  assign {gt2, eq2, lt2} = {P2 > q2_d2, P2 == q2_d2, P2 < q2_d2};

  sar_search_8b #(.BITS(8), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .PGTQ(gt0), .PEQQ(eq0), .PLTQ(lt0),
    .Q(q0), .busy(busy0), .done(done0), .result(result0),
    .found(found0), .err(err0), .trials(trials0)
  );

  sar_search_8b #(.BITS(8), .SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .PGTQ(gt2), .PEQQ(eq2), .PLTQ(lt2),
    .Q(q2), .busy(busy2), .done(done2), .result(result2),
    .found(found2), .err(err2), .trials(trials2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // qs packs the expected Q of trial 1 in the top byte, trial 2 below it, and so on.
  task automatic search0(input string name, input logic [7:0] p, input logic [63:0] qs,
                         input int ntr, input logic [7:0] exp_res, input logic exp_found,
                         input logic exp_err, input int ovr_trial, input logic [2:0] ovr_f,
                         input int pulse_trial);
    logic [7:0] last_q;
    p_val  = p;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    last_q = 8'h00;
    for (int n = 1; n <= ntr; n++) begin
      last_q = qs[63-8*(n-1) -: 8];
      check({name, " q"}, q0, last_q);
      check({name, " busy"}, busy0, 1'b1);
      if (n == ovr_trial) begin
        ovr_en      = 1'b1;
        ovr_flags_v = ovr_f;
      end
      if (n == pulse_trial) start0 = 1'b1;
      tick();
      ovr_en = 1'b0;
      start0 = 1'b0;
      if (n < ntr) check({name, " early_done"}, done0, 1'b0);
    end
    $display("search %s: result=%0h found=%0b err=%0b trials=%0d done=%0b",
             name, result0, found0, err0, trials0, done0);
    check({name, " done"}, done0, 1'b1);
    check({name, " busy_done"}, busy0, 1'b0);
    check({name, " result"}, result0, exp_res);
    check({name, " found"}, found0, exp_found);
    check({name, " err"}, err0, exp_err);
    check({name, " trials"}, trials0, ntr);
    tick();
    check({name, " done_pulse"}, done0, 1'b0);
    check({name, " idle_busy"}, busy0, 1'b0);
    check({name, " q_hold"}, q0, last_q);
    check({name, " result_hold"}, result0, exp_res);
  endtask

  task automatic check_zero0(input string name);
    check({name, " q"}, q0, 8'h00);
    check({name, " busy"}, busy0, 1'b0);
    check({name, " done"}, done0, 1'b0);
    check({name, " result"}, result0, 8'h00);
    check({name, " found"}, found0, 1'b0);
    check({name, " err"}, err0, 1'b0);
    check({name, " trials"}, trials0, 4'd0);
  endtask

  initial begin
    logic [63:0] seq2;
    rst_n       = 1'b0;
    start0      = 1'b0;
    start2      = 1'b0;
    p_val       = 8'h00;
    ovr_en      = 1'b0;
    ovr_flags_v = 3'b000;
    tick();
    tick();
    check_zero0("reset0");
    check("reset2 q", q2, 8'h00);
    check("reset2 busy", busy2, 1'b0);
    check("reset2 done", done2, 1'b0);
    rst_n = 1'b1;
    tick();

    search0("p00", 8'h00, 64'h80_40_20_10_08_04_02_01, 8, 8'h00, 1'b1, 1'b0, 0, 3'b000, 0);
    search0("p80", 8'h80, 64'h80_00_00_00_00_00_00_00, 1, 8'h80, 1'b1, 1'b0, 0, 3'b000, 0);
    search0("pA5", 8'hA5, 64'h80_C0_A0_B0_A8_A4_A6_A5, 8, 8'hA5, 1'b1, 1'b0, 0, 3'b000, 3);
    search0("inconsistent", 8'hA5, 64'h80_C0_A0_00_00_00_00_00, 3, 8'h00, 1'b0, 1'b1, 3, 3'b101, 0);
    search0("gt_at_k0", 8'hFF, 64'h80_C0_E0_F0_F8_FC_FE_FF, 8, 8'h00, 1'b0, 1'b1, 8, 3'b100, 0);

    // Abort a search of 0x3C just before its fourth evaluation.
    p_val  = 8'h3C;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    tick();
    check("mid q_before_reset", q0, 8'h30);
    rst_n  = 1'b0;
    start0 = 1'b1;
    tick();
    $display("mid-search reset: q=%0h busy=%0b trials=%0d", q0, busy0, trials0);
    check_zero0("mid_reset");
    rst_n  = 1'b1;
    start0 = 1'b0;
    tick();
    check("mid idle_after_reset busy", busy0, 1'b0);
    check("mid idle_after_reset q", q0, 8'h00);
    search0("p3C", 8'h3C, 64'h80_40_20_30_38_3C_00_00, 6, 8'h3C, 1'b1, 1'b0, 0, 3'b000, 0);

    // SETTLE=2: each Q is held for three cycles and evaluated on the third edge.
    seq2   = 64'h80_C0_E0_F0_F8_FC_FE_FF;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int idx = 1; idx <= 24; idx++) begin
      check("settle2 q", q2, seq2[63-8*((idx-1)/3) -: 8]);
      check("settle2 busy", busy2, 1'b1);
      tick();
      if (idx < 24) check("settle2 early_done", done2, 1'b0);
    end
    $display("search settle2: result=%0h found=%0b err=%0b trials=%0d done=%0b",
             result2, found2, err2, trials2, done2);
    check("settle2 done", done2, 1'b1);
    check("settle2 result", result2, 8'hFF);
    check("settle2 found", found2, 1'b1);
    check("settle2 err", err2, 1'b0);
    check("settle2 trials", trials2, 4'd8);
    tick();
    check("settle2 done_pulse", done2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
